load_store_unit: RTL and testbench

- Memory-access stage of the RISC-V pipeline, directly upstream of the MEM/WB register.
- Takes the EX/MEM load/store controls, address and store data, and runs a req/ack handshake on the data-memory bus.
- Returns aligned, sign- or zero-extended load data (feeds MEM/WB DataMemReadData_i).
- Drives the pipeline Stall line while an access is outstanding; a bus timeout keeps a dead slave from hanging the core.

---
 rtl/load_store_unit.sv | 193 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Purpose: memory-access stage; turns EX/MEM load/store controls into a req/ack data-bus transaction and formats load data.
// Latency: 2 stall cycles minimum (IDLE + one REQ), load data valid in DONE; a bus timeout ends the access after TIMEOUT_CYCLES REQ cycles.
// Backpressure: Stall_o freezes the upstream pipeline while an access is pending; mem_req_o and all bus outputs hold until mem_ack_i.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] Addr_i,
    input  logic [31:0] StoreData_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic [31:0] DataMemReadData_o,
    output logic        Stall_o,
    output logic        fault_o,
    output logic        bus_err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A zero TIMEOUT_CYCLES means the slave is trusted to always answer.
    localparam bit               TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LAST   = TIMEOUT_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       ld_f3_q;
    logic [1:0]       ld_off_q;

    logic             access;
    logic             is_store;
    logic             f3_illegal;
    logic             misaligned;
    logic             launch;
    logic             ack_done;
    logic             timeout;
    logic [3:0]       be_d;
    logic [31:0]      wdata_d;
    logic [31:0]      rd_shift;
    logic [31:0]      load_fmt;

    // Decode the incoming request: legality of funct3 and natural alignment.
    always_comb begin
        access     = MemWrite_i | MemRead_i;
        is_store   = MemWrite_i;
        f3_illegal = 1'b1;
        misaligned = 1'b0;
        case (funct3_i)
            3'b000, 3'b001, 3'b010: f3_illegal = 1'b0;
            3'b100, 3'b101:         f3_illegal = is_store;   // unsigned forms exist only for loads
            default:                f3_illegal = 1'b1;
        endcase
        case (funct3_i[1:0])
            2'b01:   misaligned = Addr_i[0];
            2'b10:   misaligned = |Addr_i[1:0];
            default: misaligned = 1'b0;
        endcase
    end

    assign fault_o = access & (f3_illegal | misaligned);

    // Byte enables and lane-replicated store data for the access size.
    always_comb begin
        be_d    = 4'b0000;
        wdata_d = StoreData_i;
        case (funct3_i[1:0])
            2'b00: begin
                be_d    = 4'b0001 << Addr_i[1:0];
                wdata_d = {4{StoreData_i[7:0]}};
            end
            2'b01: begin
                be_d    = 4'b0011 << {Addr_i[1], 1'b0};
                wdata_d = {2{StoreData_i[15:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                wdata_d = StoreData_i;
            end
        endcase
    end

    // Extract the addressed byte/half from the returned word and extend it.
    always_comb begin
        rd_shift = mem_rdata_i >> {ld_off_q, 3'b000};
        load_fmt = mem_rdata_i;
        case (ld_f3_q)
            3'b000:  load_fmt = {{24{rd_shift[7]}},  rd_shift[7:0]};
            3'b001:  load_fmt = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b100:  load_fmt = {24'd0, rd_shift[7:0]};
            3'b101:  load_fmt = {16'd0, rd_shift[15:0]};
            default: load_fmt = mem_rdata_i;
        endcase
    end

    // Next-state and stall; ack takes priority over a coincident timeout.
    always_comb begin
        state_d  = state_q;
        launch   = 1'b0;
        ack_done = 1'b0;
        timeout  = 1'b0;
        Stall_o  = 1'b0;
        case (state_q)
            IDLE: begin
                if (access && !fault_o) begin
                    launch  = 1'b1;
                    Stall_o = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                Stall_o = 1'b1;
                if (mem_ack_i) begin
                    ack_done = 1'b1;
                    state_d  = DONE;
                end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
                    timeout = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Bus outputs, load result, timeout counter and error pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_req_o         <= 1'b0;
            mem_we_o          <= 1'b0;
            mem_addr_o        <= '0;
            mem_be_o          <= '0;
            mem_wdata_o       <= '0;
            DataMemReadData_o <= '0;
            bus_err_o         <= 1'b0;
            cnt_q             <= '0;
            ld_f3_q           <= '0;
            ld_off_q          <= '0;
        end else begin
            bus_err_o <= 1'b0;
            if (launch) begin
                mem_req_o   <= 1'b1;
                mem_we_o    <= is_store;
                mem_addr_o  <= {Addr_i[31:2], 2'b00};
                mem_be_o    <= be_d;
                mem_wdata_o <= wdata_d;
                ld_f3_q     <= funct3_i;
                ld_off_q    <= Addr_i[1:0];
                cnt_q       <= '0;
            end else if (ack_done) begin
                mem_req_o <= 1'b0;
                if (!mem_we_o) begin
                    DataMemReadData_o <= load_fmt;
                end
            end else if (timeout) begin
                mem_req_o <= 1'b0;
                bus_err_o <= 1'b1;
                if (!mem_we_o) begin
                    DataMemReadData_o <= '0;   // a dead slave yields zero rather than stale data
                end
            end else if (state_q == REQ) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Purpose: self-checking bench for load_store_unit against a byte-lane reference model.
// Latency: drives one access at a time, slave acks after a random number of REQ cycles or never.
// Backpressure: inputs held while Stall_o is high, replaced once it drops.
module tb_load_store_unit;

    localparam int TO = 16;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic [2:0]  funct3_i;
    logic [31:0] Addr_i;
    logic [31:0] StoreData_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic [31:0] DataMemReadData_o;
    logic        Stall_o;
    logic        fault_o;
    logic        bus_err_o;

    load_store_unit #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i), .funct3_i(funct3_i),
        .Addr_i(Addr_i), .StoreData_i(StoreData_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .DataMemReadData_o(DataMemReadData_o), .Stall_o(Stall_o),
        .fault_o(fault_o), .bus_err_o(bus_err_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model_dout;

    // Observations of the most recent access, for the directed expectations.
    int          last_stall;
    int          last_req;
    logic        last_fault;
    logic        last_err;
    logic        last_we;
    logic [31:0] last_addr;
    logic [3:0]  last_be;
    logic [31:0] last_wdata;
    logic [31:0] last_dout;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic int size_bytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic is_legal(input logic st, input logic [2:0] f3);
        if (st) return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f3, input int off);
        logic [3:0] r;
        int nb;
        nb = size_bytes(f3);
        for (int i = 0; i < 4; i++) r[i] = (i >= off) && (i < off + nb);
        return r;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] sd);
        logic [31:0] r;
        int nb;
        nb = size_bytes(f3);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = sd[8*(i % nb) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input int off, input logic [31:0] w);
        longint v;
        longint full;
        int nb;
        nb = size_bytes(f3);
        v  = {32'd0, w};
        v  = v >> (8 * off);
        if (nb < 4) begin
            full = 64'sd1 << (8 * nb);
            v    = v % full;
            if (!f3[2] && (v >= full / 2)) v = v - full;
        end
        return v[31:0];
    endfunction

    // One access from the IDLE cycle through DONE; starts and ends at posedge+1 of an IDLE cycle.
    task automatic run_access(input logic we, input logic rd, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] sd,
                              input int ack_lat, input logic [31:0] rdata);
        logic        exp_fault;
        logic        go;
        logic        st;
        logic        timed_out;
        int          nb;
        int          off;
        int          n;
        int          exp_req;
        int          stall_cnt;
        int          req_cnt;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;

        st        = we;
        nb        = size_bytes(f3);
        off       = int'(addr[1:0]);
        exp_fault = (we | rd) && (!is_legal(st, f3) || ((int'(addr[2:0]) % nb) != 0));
        go        = (we | rd) && !exp_fault;
        exp_addr  = addr & 32'hFFFF_FFFC;
        exp_be    = ref_be(f3, off);
        exp_wdata = ref_wdata(f3, sd);

        MemWrite_i  = we;
        MemRead_i   = rd;
        funct3_i    = f3;
        Addr_i      = addr;
        StoreData_i = sd;
        mem_ack_i   = ($urandom_range(0, 3) == 0);
        mem_rdata_i = $urandom;
        @(negedge clk_i);
        last_fault = fault_o;
        chk("bus_err_idle", bus_err_o, 1'b0);
        chk("fault", fault_o, exp_fault);
        chk("stall_idle", Stall_o, go);
        chk("req_idle", mem_req_o, 1'b0);
        chk("dout_idle", DataMemReadData_o, model_dout);

        if (!go) begin
            last_stall = Stall_o ? 1 : 0;
            last_req   = 0;
            tick();
            mem_ack_i = 1'b0;
            @(negedge clk_i);
            last_stall += Stall_o ? 1 : 0;
            last_req   += mem_req_o ? 1 : 0;
            chk("req_noissue", mem_req_o, 1'b0);
            chk("stall_noissue", Stall_o, 1'b0);
            chk("dout_noissue", DataMemReadData_o, model_dout);
            last_dout = DataMemReadData_o;
            tick();
            MemWrite_i = 1'b0;
            MemRead_i  = 1'b0;
            return;
        end

        tick();
        n         = 0;
        req_cnt   = 0;
        stall_cnt = 1;
        while (n < 64) begin
            if (n == ack_lat) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = rdata;
            end else begin
                mem_ack_i   = (n > ack_lat) && ($urandom_range(0, 1) == 1);
                mem_rdata_i = $urandom;
            end
            @(negedge clk_i);
            if (!Stall_o) break;
            stall_cnt++;
            req_cnt++;
            if (req_cnt == 1) begin
                last_we    = mem_we_o;
                last_addr  = mem_addr_o;
                last_be    = mem_be_o;
                last_wdata = mem_wdata_o;
            end
            chk("req_hi", mem_req_o, 1'b1);
            chk("we", mem_we_o, st);
            chk("addr", mem_addr_o, exp_addr);
            chk("be", mem_be_o, exp_be);
            chk("wdata", mem_wdata_o, exp_wdata);
            chk("bus_err_req", bus_err_o, 1'b0);
            tick();
            n++;
        end

        timed_out = (ack_lat >= TO);
        exp_req   = timed_out ? TO : ack_lat + 1;
        if (!st) model_dout = timed_out ? 32'd0 : ref_load(f3, off, rdata);
        last_stall = stall_cnt;
        last_req   = req_cnt;
        last_err   = bus_err_o;
        last_dout  = DataMemReadData_o;
        chk("req_cycles", req_cnt, exp_req);
        chk("stall_cycles", stall_cnt, exp_req + 1);
        chk("req_done", mem_req_o, 1'b0);
        chk("bus_err_done", bus_err_o, timed_out);
        chk("dout_done", DataMemReadData_o, model_dout);
        tick();
        mem_ack_i  = 1'b0;
        MemWrite_i = 1'b0;
        MemRead_i  = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int r;
        int nb;
        logic        we;
        logic        rd;
        logic [2:0]  f3;
        logic [31:0] addr;

        rst_i       = 1'b1;
        MemRead_i   = 1'b0;
        MemWrite_i  = 1'b0;
        funct3_i    = 3'd0;
        Addr_i      = '0;
        StoreData_i = '0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        model_dout  = '0;

        tick();
        @(negedge clk_i);
        chk("rst_req", mem_req_o, 1'b0);
        chk("rst_we", mem_we_o, 1'b0);
        chk("rst_addr", mem_addr_o, 32'd0);
        chk("rst_be", mem_be_o, 4'd0);
        chk("rst_wdata", mem_wdata_o, 32'd0);
        chk("rst_dout", DataMemReadData_o, 32'd0);
        chk("rst_bus_err", bus_err_o, 1'b0);
        chk("rst_stall", Stall_o, 1'b0);
        tick();
        rst_i = 1'b0;
        tick();

        // Word load, immediate ack.
        run_access(1'b0, 1'b1, 3'b010, 32'h100, 32'd0, 0, 32'hDEADBEEF);
        chk("t1_addr", last_addr, 32'h100);
        chk("t1_be", last_be, 4'hF);
        chk("t1_stall", last_stall, 2);
        chk("t1_dout", last_dout, 32'hDEADBEEF);

        // Sub-word loads from the top lanes.
        run_access(1'b0, 1'b1, 3'b000, 32'h103, 32'd0, 1, 32'h80123456);
        chk("t2_lb_be", last_be, 4'b1000);
        chk("t2_lb", last_dout, 32'hFFFFFF80);
        run_access(1'b0, 1'b1, 3'b100, 32'h103, 32'd0, 0, 32'h80123456);
        chk("t2_lbu", last_dout, 32'h00000080);
        run_access(1'b0, 1'b1, 3'b001, 32'h102, 32'd0, 2, 32'h80123456);
        chk("t2_lh", last_dout, 32'hFFFF8012);

        // Halfword store with a slow slave.
        run_access(1'b1, 1'b0, 3'b001, 32'h206, 32'h0000ABCD, 2, 32'h0);
        chk("t3_we", last_we, 1'b1);
        chk("t3_be", last_be, 4'b1100);
        chk("t3_wdata", last_wdata, 32'hABCDABCD);
        chk("t3_stall", last_stall, 4);
        chk("t3_dout", last_dout, 32'hFFFF8012);

        // Faulting accesses never reach the bus.
        run_access(1'b0, 1'b1, 3'b010, 32'h101, 32'd0, 0, 32'h11111111);
        chk("t4_lw_fault", last_fault, 1'b1);
        chk("t4_lw_stall", last_stall, 0);
        chk("t4_lw_req", last_req, 0);
        run_access(1'b1, 1'b0, 3'b110, 32'h200, 32'h5555AAAA, 0, 32'h22222222);
        chk("t4_sw_fault", last_fault, 1'b1);
        chk("t4_sw_stall", last_stall, 0);
        chk("t4_dout", last_dout, 32'hFFFF8012);

        // Dead slave.
        run_access(1'b0, 1'b1, 3'b010, 32'h400, 32'd0, 1000, 32'h0);
        chk("t5_req", last_req, 16);
        chk("t5_err", last_err, 1'b1);
        chk("t5_dout", last_dout, 32'h0);

        // Reset in the second REQ cycle, then a late ack.
        model_dout  = 32'h0;
        MemRead_i   = 1'b1;
        funct3_i    = 3'b010;
        Addr_i      = 32'h300;
        tick();
        @(negedge clk_i);
        chk("t6_req0", mem_req_o, 1'b1);
        tick();
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("t6_req1", mem_req_o, 1'b1);
        tick();
        rst_i       = 1'b0;
        MemRead_i   = 1'b0;
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h12345678;
        @(negedge clk_i);
        chk("t6_req", mem_req_o, 1'b0);
        chk("t6_we", mem_we_o, 1'b0);
        chk("t6_addr", mem_addr_o, 32'd0);
        chk("t6_be", mem_be_o, 4'd0);
        chk("t6_wdata", mem_wdata_o, 32'd0);
        chk("t6_dout", DataMemReadData_o, 32'd0);
        chk("t6_err", bus_err_o, 1'b0);
        chk("t6_stall", Stall_o, 1'b0);
        tick();
        mem_ack_i = 1'b0;
        @(negedge clk_i);
        chk("t6_late_ack_req", mem_req_o, 1'b0);
        chk("t6_late_ack_dout", DataMemReadData_o, 32'd0);
        tick();
        run_access(1'b0, 1'b1, 3'b010, 32'h500, 32'd0, 0, 32'hCAFEF00D);
        chk("t6_after", last_dout, 32'hCAFEF00D);
        run_access(1'b0, 1'b1, 3'b101, 32'h502, 32'd0, 0, 32'hF00D1234);
        chk("t6_b2b_lhu", last_dout, 32'h0000F00D);

        // Randomized mix of loads, stores, illegal and misaligned forms.
        for (int k = 0; k < 300; k++) begin
            r  = $urandom_range(0, 9);
            we = (r == 1) || (r >= 2 && r <= 5);
            rd = (r == 1) || (r >= 6);
            f3 = 3'($urandom_range(0, 7));
            addr = $urandom;
            nb   = size_bytes(f3);
            if ($urandom_range(0, 3) != 0) addr = addr & ~(32'(nb) - 32'd1);
            run_access(we, rd, f3, addr, $urandom,
                       ($urandom_range(0, 9) == 0) ? 1000 : $urandom_range(0, 4), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
